// File: rtl/mux_scan_pkg.sv
// Shared definitions for the MUX8T1_8 channel scanner: channel geometry,
// default data width and the scanner FSM state type.
package mux_scan_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;
    localparam int W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scanner and its environment: run/step controls, the selector
// feedback byte, and the tagged capture stream.
interface mux_scan_ctrl_if
    import mux_scan_pkg::*;
#(
    parameter int W = W_DEF
);

    logic             run;
    logic             step;
    logic [W-1:0]     mux_o;
    logic [SEL_W-1:0] s;
    logic [W-1:0]     data;
    logic [SEL_W-1:0] ch;
    logic             valid;
    logic             wrap;

    modport master (
        output run, step, mux_o,
        input  s, data, ch, valid, wrap
    );

    modport slave (
        input  run, step, mux_o,
        output s, data, ch, valid, wrap
    );

endinterface

// File: rtl/MUX8T1_8.sv
// 8-to-1 byte selector fed by the scanner's select output.
module MUX8T1_8 (
    input  logic [7:0] I0,
    input  logic [7:0] I1,
    input  logic [7:0] I2,
    input  logic [7:0] I3,
    input  logic [7:0] I4,
    input  logic [7:0] I5,
    input  logic [7:0] I6,
    input  logic [7:0] I7,
    input  logic [2:0] s,
    output logic [7:0] o
);

    always_comb begin
        o = I0;
        case (s)
            3'd0: o = I0;
            3'd1: o = I1;
            3'd2: o = I2;
            3'd3: o = I3;
            3'd4: o = I4;
            3'd5: o = I5;
            3'd6: o = I6;
            3'd7: o = I7;
            default: o = I0;
        endcase
    end

endmodule

// File: rtl/mux_scan_ctrl_prescaler.sv
// Dwell prescaler: counts DIV enabled cycles and flags the terminal count.
module scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] TC = 8'(DIV - 1);

    logic [7:0] cnt;

    assign tick = en && (cnt == TC);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 8'd0;
        end else if (en) begin
            if (cnt == TC) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Channel scanner for MUX8T1_8: steps the select lines automatically (RUN) or on
// step edges (IDLE) and emits each sampled byte tagged with its channel.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DIV = 4,
    parameter int W   = W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.slave  bus
);

    state_t           state_q;
    state_t           state_d;
    logic             step_q;
    logic             step_edge;
    logic             cnt_en;
    logic             run_tick;
    logic             step_tick;
    logic             tick;
    logic [SEL_W-1:0] s_q;
    logic [SEL_W-1:0] ch_q;
    logic [W-1:0]     data_q;
    logic             valid_q;
    logic             wrap_q;

    // The prescaler is held cleared whenever it is not counting, so every RUN
    // entry starts a fresh dwell and a run drop discards partial progress.
    assign cnt_en    = (state_q == RUN) && bus.run;
    assign step_edge = bus.step && !step_q;
    assign step_tick = (state_q == IDLE) && !bus.run && step_edge;
    assign tick      = run_tick || step_tick;

    scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (!cnt_en),
        .en   (cnt_en),
        .tick (run_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.run)  state_d = RUN;
            RUN:     if (!bus.run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= bus.step;
        end
    end

    // Capture uses the select value that has been steady through the dwell,
    // then moves the selector on at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            valid_q <= tick;
            wrap_q  <= tick && (s_q == SEL_W'(NCH - 1));
            if (tick) begin
                data_q <= bus.mux_o;
                ch_q   <= s_q;
                s_q    <= s_q + 1'b1;
            end
        end
    end

    assign bus.s     = s_q;
    assign bus.ch    = ch_q;
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl driving a real MUX8T1_8 loaded with 8'h00..8'h77.
module tb_mux_scan_ctrl;

    localparam int DIV = 4;

    typedef struct packed {
        logic       rst;
        logic       run;
        logic       step;
        logic       exp_valid;
        logic       exp_wrap;
        logic [2:0] exp_ch;
        logic [7:0] exp_data;
        logic [2:0] exp_s;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] mux_out;
    logic [2:0] sel;
    int         total_count;
    int         pass_count;
    vec_t       vecs[$];

    mux_scan_ctrl_if #(.W(8)) bus ();

    assign sel       = bus.s;
    assign bus.mux_o = mux_out;

    MUX8T1_8 u_sel (
        .I0 (8'h00), .I1 (8'h11), .I2 (8'h22), .I3 (8'h33),
        .I4 (8'h44), .I5 (8'h55), .I6 (8'h66), .I7 (8'h77),
        .s  (sel),
        .o  (mux_out)
    );

    mux_scan_ctrl #(
        .DIV (DIV),
        .W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic rn, input logic st);
        rst      = r;
        bus.run  = rn;
        bus.step = st;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic v, input logic w,
                            input logic [2:0] c, input logic [7:0] d, input logic [2:0] s_exp);
        checkOutput({tag, ".valid"}, 32'(bus.valid), 32'(v));
        checkOutput({tag, ".wrap"},  32'(bus.wrap),  32'(w));
        checkOutput({tag, ".ch"},    32'(bus.ch),    32'(c));
        checkOutput({tag, ".data"},  32'(bus.data),  32'(d));
        checkOutput({tag, ".s"},     32'(bus.s),     32'(s_exp));
    endtask

    task automatic add_vec(input logic r, input logic rn, input logic st, input logic v,
                           input logic w, input logic [2:0] c, input logic [7:0] d, input logic [2:0] s_exp);
        vec_t t;
        t.rst = r; t.run = rn; t.step = st;
        t.exp_valid = v; t.exp_wrap = w; t.exp_ch = c; t.exp_data = d; t.exp_s = s_exp;
        vecs.push_back(t);
    endtask

    initial begin
        total_count = 0;
        pass_count  = 0;
        rst         = 1'b1;
        bus.run     = 1'b0;
        bus.step    = 1'b0;

        // Step-mode sweep from reset: held step gives one tick, then three pulses.
        add_vec(0,0,1, 1,0,0,8'h00,1);
        add_vec(0,0,1, 0,0,0,8'h00,1);
        add_vec(0,0,1, 0,0,0,8'h00,1);
        add_vec(0,0,1, 0,0,0,8'h00,1);
        add_vec(0,0,1, 0,0,0,8'h00,1);
        add_vec(0,0,0, 0,0,0,8'h00,1);
        add_vec(0,0,1, 1,0,1,8'h11,2);
        add_vec(0,0,0, 0,0,1,8'h11,2);
        add_vec(0,0,1, 1,0,2,8'h22,3);
        add_vec(0,0,0, 0,0,2,8'h22,3);
        add_vec(0,0,1, 1,0,3,8'h33,4);
        add_vec(0,0,0, 0,0,3,8'h33,4);
        // Reach s=5, then drop run exactly on the terminal-count edge.
        add_vec(0,0,1, 1,0,4,8'h44,5);
        add_vec(0,0,0, 0,0,4,8'h44,5);
        add_vec(0,1,0, 0,0,4,8'h44,5);
        add_vec(0,1,0, 0,0,4,8'h44,5);
        add_vec(0,1,0, 0,0,4,8'h44,5);
        add_vec(0,1,0, 0,0,4,8'h44,5);
        add_vec(0,0,0, 0,0,4,8'h44,5);
        add_vec(0,1,0, 0,0,4,8'h44,5);
        add_vec(0,1,0, 0,0,4,8'h44,5);
        add_vec(0,1,0, 0,0,4,8'h44,5);
        add_vec(0,1,0, 0,0,4,8'h44,5);
        add_vec(0,1,0, 1,0,5,8'h55,6);
        add_vec(0,1,0, 0,0,5,8'h55,6);
        add_vec(0,1,0, 0,0,5,8'h55,6);
        // Reset in RUN at s=6, cnt=2; a step tick afterwards proves IDLE.
        add_vec(1,1,0, 0,0,0,8'h00,0);
        add_vec(0,0,1, 1,0,0,8'h00,1);
        // Run rising with a step edge: no tick, first tick DIV edges later.
        add_vec(0,0,0, 0,0,0,8'h00,1);
        add_vec(0,1,1, 0,0,0,8'h00,1);
        add_vec(0,1,0, 0,0,0,8'h00,1);
        add_vec(0,1,0, 0,0,0,8'h00,1);
        add_vec(0,1,0, 0,0,0,8'h00,1);
        add_vec(0,1,0, 1,0,1,8'h11,2);
        add_vec(0,0,0, 0,0,1,8'h11,2);
        add_vec(0,0,0, 0,0,1,8'h11,2);
        // Reset on the edge where a RUN tick would have fired.
        add_vec(0,1,0, 0,0,1,8'h11,2);
        add_vec(0,1,0, 0,0,1,8'h11,2);
        add_vec(0,1,0, 0,0,1,8'h11,2);
        add_vec(0,1,0, 0,0,1,8'h11,2);
        add_vec(1,1,0, 0,0,0,8'h00,0);
        add_vec(0,0,0, 0,0,0,8'h00,0);

        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkAll("reset", 0, 0, 3'd0, 8'h00, 3'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0);
            checkAll($sformatf("idle%0d", i), 0, 0, 3'd0, 8'h00, 3'd0);
        end

        // Auto-scan: run sampled high at k=0, ticks at k=4,8,...,40.
        for (int k = 0; k <= 40; k++) begin
            int  ticks;
            int  last_ch;
            logic is_tick;
            applyStimulus(0, 1, 0);
            ticks   = k / DIV;
            is_tick = (k >= DIV) && (k % DIV == 0);
            last_ch = (ticks == 0) ? 0 : (ticks - 1) % 8;
            checkAll($sformatf("run%0d", k), is_tick, is_tick && (last_ch == 7),
                     3'(last_ch), 8'(last_ch * 8'h11), 3'(ticks % 8));
        end

        applyStimulus(0, 0, 0);
        checkAll("run_stop", 0, 0, 3'd1, 8'h11, 3'd2);
        applyStimulus(1, 0, 0);
        checkAll("reset2", 0, 0, 3'd0, 8'h00, 3'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].step);
            checkAll($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_wrap,
                     vecs[i].exp_ch, vecs[i].exp_data, vecs[i].exp_s);
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
